// File: rtl/fetch_unit.sv
// Instruction fetch stage: samples the PC on a fetch request, reads one
// 16-bit instruction over a variable-latency ack handshake, and holds it in
// the instruction register together with the incremented PC.
//
// state | meaning
// ------+-----------------------------------------------------------
// IDLE  | no fetch in flight, IR empty or already consumed
// REQ   | mem_rd asserted, waiting for mem_ack or timeout
// FULL  | IR holds an unconsumed instruction
// ERR   | fetch timed out; parked until flush or reset
module fetch_unit #(
    parameter int unsigned TIMEOUT = 15,
    parameter int unsigned INC     = 2
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic [15:0] PCOut,
    input  logic        fetch_req,
    input  logic        ir_take,
    input  logic        flush,
    output logic [15:0] mem_addr,
    output logic        mem_rd,
    input  logic        mem_ack,
    input  logic [15:0] mem_data,
    output logic [15:0] IR,
    output logic [4:0]  opcode,
    output logic [10:0] IRIn,
    output logic        ir_valid,
    output logic [15:0] pc_next,
    output logic        PCWrite,
    output logic        fetch_err
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        FULL = 2'd2,
        ERR  = 2'd3
    } state_t;

    // Last wait cycle index; an ack on this cycle still wins over the timeout.
    localparam logic [7:0]  CNT_LAST = 8'(TIMEOUT - 1);
    localparam logic [15:0] INC_W    = 16'(INC);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic [15:0] addr_q;
    logic [15:0] ir_q;
    logic [15:0] pc_next_q;
    logic        rd_q;
    logic        valid_q;
    logic        pcwrite_q;
    logic        err_q;

    // Fetch sequencer with all outputs registered; flush outranks every input.
    always_ff @(posedge CLK or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            addr_q    <= '0;
            ir_q      <= '0;
            pc_next_q <= '0;
            rd_q      <= 1'b0;
            valid_q   <= 1'b0;
            pcwrite_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            pcwrite_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (!flush && fetch_req) begin
                        state_q <= REQ;
                        addr_q  <= PCOut;
                        cnt_q   <= '0;
                        rd_q    <= 1'b1;
                    end
                end
                REQ: begin
                    if (flush) begin
                        state_q <= IDLE;
                        rd_q    <= 1'b0;
                    end else if (mem_ack) begin
                        state_q   <= FULL;
                        ir_q      <= mem_data;
                        pc_next_q <= addr_q + INC_W;
                        pcwrite_q <= 1'b1;
                        valid_q   <= 1'b1;
                        rd_q      <= 1'b0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= ERR;
                        err_q   <= 1'b1;
                        rd_q    <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                FULL: begin
                    if (flush) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end else if (ir_take) begin
                        valid_q <= 1'b0;
                        if (fetch_req) begin
                            // Back-to-back: start the next fetch as this one is consumed.
                            state_q <= REQ;
                            addr_q  <= PCOut;
                            cnt_q   <= '0;
                            rd_q    <= 1'b1;
                        end else begin
                            state_q <= IDLE;
                        end
                    end
                end
                ERR: begin
                    if (flush) begin
                        state_q <= IDLE;
                        err_q   <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign mem_addr  = addr_q;
    assign mem_rd    = rd_q;
    assign IR        = ir_q;
    assign opcode    = ir_q[15:11];
    assign IRIn      = ir_q[10:0];
    assign ir_valid  = valid_q;
    assign pc_next   = pc_next_q;
    assign PCWrite   = pcwrite_q;
    assign fetch_err = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with literal expectations plus a
// randomized phase, all compared every cycle against a transaction-level model.
module tb_fetch_unit;

    localparam int unsigned TO  = 6;
    localparam int unsigned INC = 2;

    logic        CLK;
    logic        reset;
    logic [15:0] PCOut;
    logic        fetch_req, ir_take, flush, mem_ack;
    logic [15:0] mem_data;
    logic [15:0] mem_addr, IR, pc_next;
    logic [4:0]  opcode;
    logic [10:0] IRIn;
    logic        mem_rd, ir_valid, PCWrite, fetch_err;

    fetch_unit #(.TIMEOUT(TO), .INC(INC)) dut (
        .CLK(CLK), .reset(reset), .PCOut(PCOut), .fetch_req(fetch_req),
        .ir_take(ir_take), .flush(flush), .mem_addr(mem_addr), .mem_rd(mem_rd),
        .mem_ack(mem_ack), .mem_data(mem_data), .IR(IR), .opcode(opcode),
        .IRIn(IRIn), .ir_valid(ir_valid), .pc_next(pc_next), .PCWrite(PCWrite),
        .fetch_err(fetch_err)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int ncheck = 0;
    int nfail  = 0;

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        ncheck++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an outstanding read, a held instruction, or a parked
    // error, tracked as flags plus a count of cycles spent waiting.
    logic        busy, held, err;
    int          waited;
    logic [15:0] e_addr, e_ir, e_pcn;
    logic        e_pcw;

    always @(posedge CLK or negedge reset) begin
        if (!reset) begin
            busy = 0; held = 0; err = 0; waited = 0;
            e_addr = 0; e_ir = 0; e_pcn = 0; e_pcw = 0;
        end else begin
            e_pcw = 0;
            if (flush) begin
                busy = 0; held = 0; err = 0;
            end else if (err) begin
                // only flush or reset leaves the error
            end else if (busy) begin
                waited++;
                if (mem_ack) begin
                    e_ir  = mem_data;
                    e_pcn = e_addr + 16'(INC);
                    e_pcw = 1;
                    busy  = 0;
                    held  = 1;
                end else if (waited == TO) begin
                    busy = 0;
                    err  = 1;
                end
            end else if (held) begin
                if (ir_take) begin
                    held = 0;
                    if (fetch_req) begin
                        busy = 1; waited = 0; e_addr = PCOut;
                    end
                end
            end else if (fetch_req) begin
                busy = 1; waited = 0; e_addr = PCOut;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge.
    always @(negedge CLK) begin
        chk("mem_rd",    {15'd0, mem_rd},    {15'd0, busy});
        chk("mem_addr",  mem_addr,           e_addr);
        chk("IR",        IR,                 e_ir);
        chk("opcode",    {11'd0, opcode},    {11'd0, e_ir[15:11]});
        chk("IRIn",      {5'd0, IRIn},       {5'd0, e_ir[10:0]});
        chk("ir_valid",  {15'd0, ir_valid},  {15'd0, held});
        chk("pc_next",   pc_next,            e_pcn);
        chk("PCWrite",   {15'd0, PCWrite},   {15'd0, e_pcw});
        chk("fetch_err", {15'd0, fetch_err}, {15'd0, err});
    end

    int rd_cnt = 0;
    always @(negedge CLK) if (mem_rd === 1'b1) rd_cnt++;

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_fetch(input logic [15:0] addr, input logic [15:0] data, input int delay);
        PCOut = addr; fetch_req = 1; tick; fetch_req = 0;
        repeat (delay) tick;
        mem_ack = 1; mem_data = data; tick; mem_ack = 0;
    endtask

    task automatic take;
        ir_take = 1; tick; ir_take = 0;
    endtask

    initial begin
        reset = 1; PCOut = 0; fetch_req = 0; ir_take = 0; flush = 0;
        mem_ack = 0; mem_data = 0;
        #1 reset = 0;
        repeat (2) tick;
        chk("rst mem_rd", {15'd0, mem_rd}, 16'd0);
        chk("rst IR", IR, 16'd0);
        reset = 1;
        tick;

        // Basic fetch, ack on first REQ cycle.
        PCOut = 16'h0040; fetch_req = 1; tick; fetch_req = 0;
        chk("t1 mem_rd", {15'd0, mem_rd}, 16'd1);
        chk("t1 mem_addr", mem_addr, 16'h0040);
        mem_ack = 1; mem_data = 16'hA7FF; tick; mem_ack = 0;
        chk("t1 IR", IR, 16'hA7FF);
        chk("t1 opcode", {11'd0, opcode}, 16'h0014);
        chk("t1 IRIn", {5'd0, IRIn}, 16'h07FF);
        chk("t1 pc_next", pc_next, 16'h0042);
        chk("t1 PCWrite", {15'd0, PCWrite}, 16'd1);
        chk("t1 ir_valid", {15'd0, ir_valid}, 16'd1);
        tick;
        chk("t1 PCWrite drop", {15'd0, PCWrite}, 16'd0);
        take;

        // Ack on the fifth wait cycle, PC wrap.
        rd_cnt = 0;
        do_fetch(16'hFFFE, 16'h1357, 4);
        chk("t2 rd cycles", 16'(rd_cnt), 16'd5);
        chk("t2 pc_next wrap", pc_next, 16'h0000);
        chk("t2 IR", IR, 16'h1357);
        take;

        // Timeout: exactly TO read cycles, then sticky error.
        rd_cnt = 0;
        PCOut = 16'h0200; fetch_req = 1; tick; fetch_req = 0;
        repeat (10) tick;
        chk("t3 rd cycles", 16'(rd_cnt), 16'(TO));
        chk("t3 fetch_err", {15'd0, fetch_err}, 16'd1);
        fetch_req = 1; tick; fetch_req = 0;
        chk("t3 req in ERR", {15'd0, mem_rd}, 16'd0);
        chk("t3 err sticky", {15'd0, fetch_err}, 16'd1);
        flush = 1; tick; flush = 0;
        chk("t3 flush clears", {15'd0, fetch_err}, 16'd0);

        // Ack on the last allowed cycle completes normally.
        do_fetch(16'h0300, 16'h5A5A, TO - 1);
        chk("t4 ir_valid", {15'd0, ir_valid}, 16'd1);
        chk("t4 fetch_err", {15'd0, fetch_err}, 16'd0);
        chk("t4 IR", IR, 16'h5A5A);
        take;

        // Flush with simultaneous ack in REQ discards the data.
        PCOut = 16'h0400; fetch_req = 1; tick; fetch_req = 0;
        flush = 1; mem_ack = 1; mem_data = 16'h1234; tick; flush = 0; mem_ack = 0;
        chk("t5 IR kept", IR, 16'h5A5A);
        chk("t5 PCWrite", {15'd0, PCWrite}, 16'd0);
        chk("t5 mem_rd", {15'd0, mem_rd}, 16'd0);
        chk("t5 ir_valid", {15'd0, ir_valid}, 16'd0);

        // Flush in FULL.
        do_fetch(16'h0500, 16'h2468, 0);
        flush = 1; tick; flush = 0;
        chk("t6 ir_valid", {15'd0, ir_valid}, 16'd0);
        chk("t6 IR holds", IR, 16'h2468);

        // Back-to-back, then fetch_req alone in FULL.
        do_fetch(16'h0600, 16'h0F0F, 1);
        PCOut = 16'h0100; ir_take = 1; fetch_req = 1; tick; ir_take = 0; fetch_req = 0;
        chk("t7 mem_rd", {15'd0, mem_rd}, 16'd1);
        chk("t7 mem_addr", mem_addr, 16'h0100);
        chk("t7 ir_valid", {15'd0, ir_valid}, 16'd0);
        mem_ack = 1; mem_data = 16'hBEEF; tick; mem_ack = 0;
        chk("t7 pc_next", pc_next, 16'h0102);
        PCOut = 16'h0700; fetch_req = 1; tick; fetch_req = 0;
        chk("t7 req ignored", {15'd0, mem_rd}, 16'd0);
        chk("t7 still full", {15'd0, ir_valid}, 16'd1);
        take;

        // Asynchronous reset mid-REQ, late ack ignored.
        PCOut = 16'h0800; fetch_req = 1; tick; fetch_req = 0;
        #1 reset = 0;
        #1;
        chk("t8 mem_rd async", {15'd0, mem_rd}, 16'd0);
        chk("t8 mem_addr", mem_addr, 16'h0000);
        chk("t8 IR", IR, 16'h0000);
        chk("t8 pc_next", pc_next, 16'h0000);
        tick;
        mem_ack = 1; mem_data = 16'hDEAD; reset = 1; tick; mem_ack = 0;
        chk("t8 late ack", {15'd0, ir_valid}, 16'd0);
        chk("t8 IR after", IR, 16'h0000);

        // Randomized traffic against the model.
        for (int i = 0; i < 2000; i++) begin
            PCOut     = 16'($urandom);
            mem_data  = 16'($urandom);
            fetch_req = ($urandom_range(0, 99) < 50);
            mem_ack   = ($urandom_range(0, 99) < 30);
            ir_take   = ($urandom_range(0, 99) < 30);
            flush     = ($urandom_range(0, 99) < 4);
            tick;
        end
        fetch_req = 0; mem_ack = 0; ir_take = 0; flush = 0;
        repeat (2) tick;

        $display("End of test - %0d assertions evaluated, %0d failures", ncheck, nfail);
        $finish;
    end

endmodule
